// File: rtl/mbc_pkg.sv
// Shared MBC definitions: console bus region map, register reset values and
// the registered read-source select used by the cartridge responders.
package mbc_pkg;

    localparam logic [15:0] ROM0_HI      = 16'h3FFF;
    localparam logic [15:0] ROMX_HI      = 16'h7FFF;
    localparam logic [15:0] CRAM_LO      = 16'hA000;
    localparam logic [15:0] CRAM_HI      = 16'hBFFF;

    // Upper bounds of the four register windows inside 0x0000-0x7FFF
    localparam logic [15:0] REG_RAMEN_HI = 16'h1FFF;
    localparam logic [15:0] REG_BANK1_HI = 16'h3FFF;
    localparam logic [15:0] REG_BANK2_HI = 16'h5FFF;
    localparam logic [15:0] REG_MODE_HI  = 16'h7FFF;

    localparam logic [3:0]  RAM_EN_KEY   = 4'hA;

    localparam logic        RST_RAM_EN   = 1'b0;
    localparam logic [4:0]  RST_BANK1    = 5'd1;
    localparam logic [1:0]  RST_BANK2    = 2'd0;
    localparam logic        RST_MODE     = 1'b0;
    localparam logic [7:0]  RST_DOUT     = 8'hFF;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_ROM  = 2'd1,
        RD_RAM  = 2'd2
    } rd_sel_t;

endpackage

// File: rtl/mbc1_regs.sv
// MBC1 control registers: write-edge detection plus RAM gate, BANK1, BANK2
// and banking-mode registers written through the 0x0000-0x7FFF window.
module mbc1_regs
    import mbc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic [2:0] i_a_hi,
    input  logic [4:0] i_din,
    output logic       o_wr_edge,
    output logic       o_ram_en,
    output logic [4:0] o_bank1,
    output logic [1:0] o_bank2,
    output logic       o_mode
);

    logic        r_wr_q;
    logic        r_ram_en;
    logic [4:0]  r_bank1;
    logic [1:0]  r_bank2;
    logic        r_mode;
    logic        w_wr_edge;
    logic [15:0] w_a_base;

    assign w_a_base  = {i_a_hi, 13'h0000};
    assign w_wr_edge = i_wr & ~r_wr_q;

    // r_wr_q resets high so a write held across reset release is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_q   <= 1'b1;
            r_ram_en <= RST_RAM_EN;
            r_bank1  <= RST_BANK1;
            r_bank2  <= RST_BANK2;
            r_mode   <= RST_MODE;
        end else begin
            r_wr_q <= i_wr;
            if (w_wr_edge) begin
                if (w_a_base <= REG_RAMEN_HI) begin
                    r_ram_en <= (i_din[3:0] == RAM_EN_KEY);
                end else if (w_a_base <= REG_BANK1_HI) begin
                    // Zero test on all five bits, before any ROM-size masking
                    r_bank1 <= (i_din == 5'd0) ? 5'd1 : i_din;
                end else if (w_a_base <= REG_BANK2_HI) begin
                    r_bank2 <= i_din[1:0];
                end else if (w_a_base <= REG_MODE_HI) begin
                    r_mode <= i_din[0];
                end
            end
        end
    end

    assign o_wr_edge = w_wr_edge;
    assign o_ram_en  = r_ram_en;
    assign o_bank1   = r_bank1;
    assign o_bank2   = r_bank2;
    assign o_mode    = r_mode;

endmodule

// File: rtl/mbc1_cart.sv
// MBC1 cartridge responder: maps console bus cycles onto linear ROM and
// cartridge-RAM addresses and returns read data one clock later.
module mbc1_cart
    import mbc_pkg::*;
#(
    parameter int unsigned ROM_ABITS = 19,
    parameter int unsigned RAM_ABITS = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          a,
    input  logic [7:0]           din,
    output logic [7:0]           dout,
    input  logic                 wr,
    input  logic                 rd,
    output logic [ROM_ABITS-1:0] rom_a,
    input  logic [7:0]           rom_q,
    output logic [RAM_ABITS-1:0] ram_a,
    output logic [7:0]           ram_d,
    output logic                 ram_we,
    input  logic [7:0]           ram_q,
    output logic                 ram_enabled
);

    logic       w_wr_edge;
    logic       w_ram_en;
    logic [4:0] w_bank1;
    logic [1:0] w_bank2;
    logic       w_mode;
    logic       w_is_rom;
    logic       w_is_cram;
    logic [6:0] w_rom_bank;
    logic [1:0] w_ram_bank;
    rd_sel_t    r_rd_sel;
    rd_sel_t    w_rd_sel_nxt;

    mbc1_regs u_regs (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (wr),
        .i_a_hi    (a[15:13]),
        .i_din     (din[4:0]),
        .o_wr_edge (w_wr_edge),
        .o_ram_en  (w_ram_en),
        .o_bank1   (w_bank1),
        .o_bank2   (w_bank2),
        .o_mode    (w_mode)
    );

    assign w_is_rom  = (a <= ROMX_HI);
    assign w_is_cram = (a >= CRAM_LO) && (a <= CRAM_HI);

    always_comb begin
        w_rom_bank = '0;
        if (a <= ROM0_HI) begin
            w_rom_bank = w_mode ? {w_bank2, 5'b00000} : 7'd0;
        end else begin
            w_rom_bank = {w_bank2, w_bank1};
        end
    end

    assign w_ram_bank = w_mode ? w_bank2 : 2'd0;

    // Dropping the upper bank bits gives the mirror behaviour of smaller ROMs
    assign rom_a  = ROM_ABITS'({w_rom_bank, a[13:0]});
    assign ram_a  = RAM_ABITS'({w_ram_bank, a[12:0]});
    assign ram_d  = din;
    assign ram_we = w_wr_edge & w_ram_en & w_is_cram;

    always_comb begin
        w_rd_sel_nxt = RD_NONE;
        if (rd && !wr) begin
            if (w_is_rom) begin
                w_rd_sel_nxt = RD_ROM;
            end else if (w_is_cram && w_ram_en) begin
                w_rd_sel_nxt = RD_RAM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_sel <= RD_NONE;
        end else begin
            r_rd_sel <= w_rd_sel_nxt;
        end
    end

    always_comb begin
        dout = RST_DOUT;
        case (r_rd_sel)
            RD_ROM:  dout = rom_q;
            RD_RAM:  dout = ram_q;
            default: dout = RST_DOUT;
        endcase
    end

    assign ram_enabled = w_ram_en;

endmodule

// File: tb/tb_mbc1_cart.sv
// Self-checking bench for mbc1_cart: directed and random bus cycles checked
// against an arithmetic model of the MBC1 banking rules.
module tb_mbc1_cart;

    localparam int unsigned ROM_ABITS = 19;
    localparam int unsigned RAM_ABITS = 15;
    localparam int unsigned RAM_SIZE  = 1 << RAM_ABITS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [15:0]          a;
    logic [7:0]           din;
    logic [7:0]           dout;
    logic                 wr;
    logic                 rd;
    logic [ROM_ABITS-1:0] rom_a;
    logic [7:0]           rom_q;
    logic [RAM_ABITS-1:0] ram_a;
    logic [7:0]           ram_d;
    logic                 ram_we;
    logic [7:0]           ram_q;
    logic                 ram_enabled;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   we_cnt   = 0;
    logic mem_clr  = 1'b1;

    logic [7:0] mem     [RAM_SIZE];
    logic [7:0] ref_ram [RAM_SIZE];

    bit          m_ram_en;
    int unsigned m_bank1;
    int unsigned m_bank2;
    int unsigned m_mode;

    mbc1_cart #(
        .ROM_ABITS (ROM_ABITS),
        .RAM_ABITS (RAM_ABITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .din         (din),
        .dout        (dout),
        .wr          (wr),
        .rd          (rd),
        .rom_a       (rom_a),
        .rom_q       (rom_q),
        .ram_a       (ram_a),
        .ram_d       (ram_d),
        .ram_we      (ram_we),
        .ram_q       (ram_q),
        .ram_enabled (ram_enabled)
    );

    always #5 clk = ~clk;

    // Every address bit changes the byte, so a wrong bank shows up in dout
    function automatic logic [7:0] rom_byte(input logic [20:0] addr);
        return addr[7:0] ^ addr[15:8] ^ {addr[20:16], 3'b101};
    endfunction

    always @(posedge clk) rom_q <= rom_byte(21'(rom_a));

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < RAM_SIZE; i++) mem[i] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_a] <= ram_d;
        end
        ram_q <= mem[ram_a];
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_assert++;
        assert (got === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
        end
    endtask

    function automatic bit is_cram(input int unsigned addr);
        return (addr >= 32'hA000) && (addr < 32'hC000);
    endfunction

    function automatic int unsigned exp_rom_a(input int unsigned addr);
        int unsigned bank;
        if (addr < 32'h4000) bank = (m_mode != 0) ? m_bank2 * 32 : 0;
        else                 bank = m_bank2 * 32 + m_bank1;
        return (bank * 16384 + addr % 16384) % (1 << ROM_ABITS);
    endfunction

    function automatic int unsigned exp_ram_a(input int unsigned addr);
        int unsigned bank;
        bank = (m_mode != 0) ? m_bank2 : 0;
        return (bank * 8192 + addr % 8192) % (1 << RAM_ABITS);
    endfunction

    function automatic logic [7:0] exp_dout(input int unsigned addr);
        if (addr < 32'h8000)           return rom_byte(21'(exp_rom_a(addr)));
        if (is_cram(addr) && m_ram_en) return ref_ram[exp_ram_a(addr)];
        return 8'hFF;
    endfunction

    task automatic model_write(input int unsigned addr, input int unsigned data);
        if (addr < 32'h2000)      m_ram_en = ((data % 16) == 10);
        else if (addr < 32'h4000) m_bank1 = ((data % 32) == 0) ? 1 : data % 32;
        else if (addr < 32'h6000) m_bank2 = data % 4;
        else if (addr < 32'h8000) m_mode = data % 2;
        else if (is_cram(addr) && m_ram_en) ref_ram[exp_ram_a(addr)] = 8'(data);
    endtask

    task automatic model_reset();
        m_ram_en = 1'b0;
        m_bank1  = 1;
        m_bank2  = 0;
        m_mode   = 0;
    endtask

    // Write held for 'hold' clocks; din is scrambled after the first clock
    task automatic bus_write(input int unsigned addr, input logic [7:0] data, input int unsigned hold);
        int base;
        bit exp_we;
        exp_we = is_cram(addr) && m_ram_en;
        @(negedge clk);
        base = we_cnt;
        a = addr[15:0]; din = data; wr = 1'b1; rd = 1'b0;
        #1;
        chk("ram_we_first", 32'(ram_we), 32'(exp_we));
        if (exp_we) begin
            chk("ram_a_wr", 32'(ram_a), exp_ram_a(addr));
            chk("ram_d", 32'(ram_d), 32'(data));
        end
        for (int unsigned k = 1; k < hold; k++) begin
            @(negedge clk);
            din = 8'($urandom);
            #1;
            chk("ram_we_held", 32'(ram_we), 32'd0);
        end
        @(negedge clk);
        wr = 1'b0;
        model_write(addr, 32'(data));
        #1;
        chk("we_count", 32'(we_cnt - base), 32'(exp_we));
    endtask

    task automatic bus_read(input int unsigned addr);
        logic [7:0] exp_d;
        @(negedge clk);
        a = addr[15:0]; rd = 1'b1; wr = 1'b0;
        #1;
        if (addr < 32'h8000) chk("rom_a", 32'(rom_a), exp_rom_a(addr));
        if (is_cram(addr))   chk("ram_a_rd", 32'(ram_a), exp_ram_a(addr));
        exp_d = exp_dout(addr);
        @(negedge clk);
        #1;
        chk("dout_rd", 32'(dout), 32'(exp_d));
        rd = 1'b0;
        @(negedge clk);
        #1;
        chk("dout_idle", 32'(dout), 32'hFF);
    endtask

    task automatic rom_peek(input logic [15:0] addr, input logic [31:0] exp_v);
        a = addr;
        #1;
        chk("rom_a_const", 32'(rom_a), exp_v);
    endtask

    task automatic ram_peek(input logic [15:0] addr, input logic [31:0] exp_v);
        a = addr;
        #1;
        chk("ram_a_const", 32'(ram_a), exp_v);
    endtask

    initial begin
        int unsigned r;
        int unsigned addr;
        int unsigned region;
        logic [7:0]  data;
        int          base;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; a = 16'h0000; din = 8'h00;
        model_reset();
        for (int i = 0; i < RAM_SIZE; i++) ref_ram[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'hFF);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_enabled", 32'(ram_enabled), 32'd0);
        mem_clr = 1'b0;
        rst = 1'b0;

        // Power-on banking
        bus_read(32'h4123); rom_peek(16'h4123, 32'h04123);
        bus_read(32'h0100); rom_peek(16'h0100, 32'h00100);

        // BANK1 zero handling and ROM-size masking
        bus_write(32'h2000, 8'h00, 1); rom_peek(16'h4000, 32'h04000); bus_read(32'h4000);
        bus_write(32'h2000, 8'h20, 1); rom_peek(16'h4000, 32'h04000);
        bus_write(32'h2000, 8'h1F, 1); rom_peek(16'h4000, 32'h7C000); bus_read(32'h4000);

        // RAM gate closed then opened
        bus_write(32'hA010, 8'h55, 1); bus_read(32'hA010);
        bus_write(32'h0000, 8'h0A, 1);
        #1 chk("ram_enabled_on", 32'(ram_enabled), 32'd1);
        bus_write(32'hA010, 8'h55, 1); ram_peek(16'hA010, 32'h0010);
        bus_read(32'hA010);

        // Mode 1 with BANK2 = 2
        bus_write(32'h4000, 8'h02, 1);
        bus_write(32'h6000, 8'h01, 1);
        rom_peek(16'h0000, 32'h00000);
        rom_peek(16'h4000, 32'h7C000);
        ram_peek(16'hA000, 32'h4000);
        bus_read(32'h0000); bus_read(32'hA000); bus_read(32'h5ABC);

        // Long write with changing din commits only the first value
        bus_write(32'hA020, 8'h3C, 4);
        bus_read(32'hA020);

        // Simultaneous rd and wr: write taken, read returns FF
        @(negedge clk);
        a = 16'h6000; din = 8'h01; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        #1 chk("rd_wr_dout", 32'(dout), 32'hFF);
        rd = 1'b0; wr = 1'b0;
        model_write(32'h6000, 32'h01);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            region = $urandom_range(0, 4);
            case (region)
                0: addr = 32'h0000;
                1: addr = 32'h2000;
                2: addr = 32'h4000;
                3: addr = 32'h6000;
                default: addr = 32'hA000;
            endcase
            addr = addr + $urandom_range(0, 32'h1FFF);
            if (r < 4) begin
                data = 8'($urandom);
                if (region == 0 && $urandom_range(0, 1) == 1) data = {data[7:4], 4'hA};
                bus_write(addr, data, $urandom_range(1, 3));
            end else begin
                if (r == 9) addr = $urandom_range(0, 32'hFFFF);
                bus_read(addr);
            end
        end

        // Reset asserted during a RAM-enable write and released with wr still high
        bus_write(32'h0000, 8'h0A, 1);
        @(negedge clk);
        base = we_cnt;
        rst = 1'b1; a = 16'h0000; din = 8'h0A; wr = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rstwr_ram_enabled", 32'(ram_enabled), 32'd0);
        chk("rstwr_dout", 32'(dout), 32'hFF);
        chk("rstwr_we_count", 32'(we_cnt - base), 32'd0);
        wr = 1'b0;
        model_reset();
        rom_peek(16'h4000, 32'h04000);
        rom_peek(16'h0000, 32'h00000);
        ram_peek(16'hA123, 32'h0123);
        bus_read(32'h4000); bus_read(32'h0000); bus_read(32'hA030);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
